// File: rtl/mem_arbiter_pkg.sv
// Shared hold-flag/write-enable/state encodings and types for the core memory arbiter.
`ifndef HOLD_FLAG_BUS
`define HOLD_FLAG_BUS 2:0
`define HOLD_NONE     3'b000
`define HOLD_PC       3'b001
`define HOLD_ID       3'b011
`define WRITE_ENABLE  1'b1
`define WRITE_DISABLE 1'b0
`define ZERO_WORD     32'h0
`define ARB_IDLE      2'b00
`define ARB_RD0       2'b01
`define ARB_RD1       2'b10
`endif

package mem_arbiter_pkg;

  localparam int unsigned HOLD_W = 3;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    ARB_ST_IDLE = `ARB_IDLE,
    ARB_ST_RD0  = `ARB_RD0,
    ARB_ST_RD1  = `ARB_RD1
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Shares the single-port core memory between fetch (m0) and ex load/store (m1).
// Build option MEM_ARB_STARVE_GUARD_EN adds the m0 starvation guard.
`ifndef HOLD_FLAG_BUS
`define HOLD_FLAG_BUS 2:0
`define HOLD_NONE     3'b000
`define HOLD_PC       3'b001
`define HOLD_ID       3'b011
`define WRITE_ENABLE  1'b1
`define WRITE_DISABLE 1'b0
`define ZERO_WORD     32'h0
`define ARB_IDLE      2'b00
`define ARB_RD0       2'b01
`define ARB_RD1       2'b10
`endif

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m0_req,
  input  logic [ADDR_W-1:0]    m0_addr,
  output logic                 m0_gnt,
  output logic                 m0_rvalid,
  output logic [DATA_W-1:0]    m0_rdata,
  input  logic                 m1_req,
  input  logic                 m1_we,
  input  logic [ADDR_W-1:0]    m1_addr,
  input  logic [DATA_W-1:0]    m1_wdata,
  output logic                 m1_gnt,
  output logic                 m1_rvalid,
  output logic [DATA_W-1:0]    m1_rdata,
  output logic                 s_req,
  output logic                 s_we,
  output logic [ADDR_W-1:0]    s_addr,
  output logic [DATA_W-1:0]    s_wdata,
  input  logic [DATA_W-1:0]    s_rdata,
  output logic [`HOLD_FLAG_BUS] hold_flag_o
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  arb_state_e state_q, state_d;
  logic       starved_c;

  // Tracks which master owns the single outstanding read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Counts consecutive cycles fetch was denied; saturates at the limit.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (m0_gnt) begin
      starve_cnt_d = '0;
    end else if (m0_req && (starve_cnt_q != STARVE_LIM)) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  assign starved_c = (starve_cnt_q == STARVE_LIM);
`else
  // Without the guard ex always wins and the limit has no effect.
  logic unused_starve_lim;
  assign starved_c         = 1'b0;
  assign unused_starve_lim = ^STARVE_LIM;
`endif

  // Arbitration, slave drive, response routing and hold flag; all quiet during reset.
  always_comb begin
    state_d     = ARB_ST_IDLE;
    m0_gnt      = 1'b0;
    m1_gnt      = 1'b0;
    m0_rvalid   = 1'b0;
    m0_rdata    = '0;
    m1_rvalid   = 1'b0;
    m1_rdata    = '0;
    s_req       = 1'b0;
    s_we        = `WRITE_DISABLE;
    s_addr      = '0;
    s_wdata     = '0;
    hold_flag_o = `HOLD_NONE;

    if (!rst) begin
      if (m0_req && (!m1_req || starved_c)) begin
        m0_gnt = 1'b1;
      end else if (m1_req) begin
        m1_gnt = 1'b1;
      end

      if (m0_gnt) begin
        s_req   = 1'b1;
        s_we    = `WRITE_DISABLE;
        s_addr  = m0_addr;
        state_d = ARB_ST_RD0;
      end else if (m1_gnt) begin
        s_req   = 1'b1;
        s_we    = m1_we;
        s_addr  = m1_addr;
        s_wdata = m1_wdata;
        state_d = (m1_we == `WRITE_ENABLE) ? ARB_ST_IDLE : ARB_ST_RD1;
      end

      case (state_q)
        ARB_ST_RD0: begin
          m0_rvalid = 1'b1;
          m0_rdata  = s_rdata;
        end
        ARB_ST_RD1: begin
          m1_rvalid = 1'b1;
          m1_rdata  = s_rdata;
        end
        default: ;
      endcase

      if (m1_req && !m1_gnt) begin
        hold_flag_o = `HOLD_ID;
      end else if (m0_req && !m0_gnt) begin
        hold_flag_o = `HOLD_PC;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed cycles push expectations, a negedge monitor checks them.
module tb_mem_arbiter;

  localparam logic [2:0] H_NONE = 3'b000;
  localparam logic [2:0] H_PC   = 3'b001;
  localparam logic [2:0] H_ID   = 3'b011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0;
  logic [31:0] m0_addr = 32'h0;
  logic        m0_gnt, m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m1_req = 1'b0;
  logic        m1_we = 1'b0;
  logic [31:0] m1_addr = 32'h0;
  logic [31:0] m1_wdata = 32'h0;
  logic        m1_gnt, m1_rvalid;
  logic [31:0] m1_rdata;
  logic        s_req, s_we;
  logic [31:0] s_addr, s_wdata;
  logic [31:0] s_rdata = 32'h0;
  logic [2:0]  hold_flag_o;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .hold_flag_o(hold_flag_o)
  );

  always #5 clk = ~clk;

  // Memory model: write in the grant cycle, read data on the following cycle.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (s_req) begin
      if (s_we) mem[s_addr[7:0]] <= s_wdata;
      else      s_rdata <= mem[s_addr[7:0]];
    end
  end

  typedef struct packed {
    logic        g0, g1, rv0, rv1, sreq, swe;
    logic [31:0] saddr, swdata;
    logic [2:0]  hold;
  } cyc_t;

  typedef struct packed {
    logic        mst;
    logic [31:0] data;
  } rsp_t;

  cyc_t cyc_q[$];
  rsp_t rsp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Monitor: per-cycle expectations plus an in-order response scoreboard.
  always @(negedge clk) begin : mon
    cyc_t e;
    rsp_t r;
    if (cyc_q.size() > 0) begin
      e = cyc_q.pop_front();
      chk("m0_gnt",    32'(m0_gnt),      32'(e.g0));
      chk("m1_gnt",    32'(m1_gnt),      32'(e.g1));
      chk("hold_flag", 32'(hold_flag_o), 32'(e.hold));
      chk("s_req",     32'(s_req),       32'(e.sreq));
      chk("s_we",      32'(s_we),        32'(e.swe));
      chk("s_addr",    s_addr,           e.saddr);
      if (e.swe) chk("s_wdata", s_wdata, e.swdata);
      chk("m0_rvalid", 32'(m0_rvalid),   32'(e.rv0));
      chk("m1_rvalid", 32'(m1_rvalid),   32'(e.rv1));
    end
    if (m0_rvalid) begin
      if (rsp_q.size() == 0) chk("m0_rvalid_unexpected", 32'(m0_rvalid), 32'h0);
      else begin
        r = rsp_q.pop_front();
        chk("m0_rsp_owner", 32'h0, 32'(r.mst));
        chk("m0_rdata", m0_rdata, r.data);
      end
    end else begin
      chk("m0_rdata_idle", m0_rdata, 32'h0);
    end
    if (m1_rvalid) begin
      if (rsp_q.size() == 0) chk("m1_rvalid_unexpected", 32'(m1_rvalid), 32'h0);
      else begin
        r = rsp_q.pop_front();
        chk("m1_rsp_owner", 32'h1, 32'(r.mst));
        chk("m1_rdata", m1_rdata, r.data);
      end
    end else begin
      chk("m1_rdata_idle", m1_rdata, 32'h0);
    end
  end

  task automatic step(input logic r0, input logic [31:0] a0,
                      input logic r1, input logic we, input logic [31:0] a1, input logic [31:0] wd,
                      input logic g0, input logic g1, input logic [2:0] h,
                      input logic rv0, input logic rv1);
    cyc_t e;
    m0_req   = r0;
    m0_addr  = a0;
    m1_req   = r1;
    m1_we    = we;
    m1_addr  = a1;
    m1_wdata = wd;
    e.g0     = g0;
    e.g1     = g1;
    e.rv0    = rv0;
    e.rv1    = rv1;
    e.sreq   = g0 | g1;
    e.swe    = g1 & we;
    e.saddr  = g0 ? a0 : (g1 ? a1 : 32'h0);
    e.swdata = wd;
    e.hold   = h;
    cyc_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic rsp(input logic mst, input logic [31:0] data);
    rsp_t r;
    r.mst  = mst;
    r.data = data;
    rsp_q.push_back(r);
  endtask

  task automatic idle(input logic rv0, input logic rv1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, H_NONE, rv0, rv1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = 32'hDEADBEEF;
    mem[8'h14] = 32'hCAFE0014;
    mem[8'h18] = 32'hA5A50018;

    @(posedge clk);
    #1;
    // Outputs stay at reset values while requests are driven under reset.
    step(1'b1, 32'h10, 1'b1, 1'b0, 32'h18, 32'h0, 1'b0, 1'b0, H_NONE, 1'b0, 1'b0);
    step(1'b1, 32'h10, 1'b1, 1'b1, 32'h18, 32'h55, 1'b0, 1'b0, H_NONE, 1'b0, 1'b0);
    rst = 1'b0;

    // Lone fetch read, data one cycle later.
    rsp(1'b0, 32'hDEADBEEF);
    step(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, H_NONE, 1'b0, 1'b0);
    idle(1'b1, 1'b0);

    // Simultaneous reads: ex wins, fetch follows while ex data returns.
    rsp(1'b1, 32'hA5A50018);
    step(1'b1, 32'h14, 1'b1, 1'b0, 32'h18, 32'h0, 1'b0, 1'b1, H_PC, 1'b0, 1'b0);
    rsp(1'b0, 32'hCAFE0014);
    step(1'b1, 32'h14, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, H_NONE, 1'b0, 1'b1);

    // Write then read-back of the same word.
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0, 1'b1, H_NONE, 1'b1, 1'b0);
    rsp(1'b0, 32'h12345678);
    step(1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, H_NONE, 1'b0, 1'b0);
    idle(1'b1, 1'b0);

    // Ex read granted while a fetch read is outstanding; responses stay separate.
    rsp(1'b0, 32'hDEADBEEF);
    step(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, H_NONE, 1'b0, 1'b0);
    rsp(1'b1, 32'hA5A50018);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h18, 32'h0, 1'b0, 1'b1, H_NONE, 1'b1, 1'b0);
    idle(1'b0, 1'b1);

    // Both masters requesting continuously (ex writes).
`ifdef MEM_ARB_STARVE_GUARD_EN
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'h10, 1'b1, 1'b1, 32'h30, 32'h0BAD0030, 1'b0, 1'b1, H_PC, 1'b0, 1'b0);
    rsp(1'b0, 32'hDEADBEEF);
    step(1'b1, 32'h10, 1'b1, 1'b1, 32'h30, 32'h0BAD0030, 1'b1, 1'b0, H_ID, 1'b0, 1'b0);
    step(1'b1, 32'h10, 1'b1, 1'b1, 32'h30, 32'h0BAD0030, 1'b0, 1'b1, H_PC, 1'b1, 1'b0);
`else
    for (int i = 0; i < 6; i++)
      step(1'b1, 32'h10, 1'b1, 1'b1, 32'h30, 32'h0BAD0030, 1'b0, 1'b1, H_PC, 1'b0, 1'b0);
`endif
    idle(1'b0, 1'b0);

    // Reset in the cycle after an ex read grant discards the read.
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h18, 32'h0, 1'b0, 1'b1, H_NONE, 1'b0, 1'b0);
    rst = 1'b1;
    step(1'b1, 32'h10, 1'b1, 1'b0, 32'h18, 32'h0, 1'b0, 1'b0, H_NONE, 1'b0, 1'b0);
    rst = 1'b0;
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);

    // Normal operation resumes after reset.
    rsp(1'b0, 32'hDEADBEEF);
    step(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, H_NONE, 1'b0, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b0);

    chk("rsp_queue_drained", 32'(rsp_q.size()), 32'h0);
    chk("cyc_queue_drained", 32'(cyc_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master, one-slave arbiter sharing the single-port core memory between instruction fetch (master 0) and the execute stage's load/store path (master 1). Accepts at most one transaction per cycle, tracks the one outstanding read, and routes its returned data to the owning master. Raises the pipeline hold flag whenever a requester is blocked. Sits between pc_reg/ex and the memory model, replacing their direct memory connections.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive denied cycles before master 0 is forced to win (range 1..15)

- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- m0_req  in  1  fetch read request
- m0_addr  in  ADDR_W  fetch address
- m0_gnt  out  1  fetch request accepted this cycle
- m0_rvalid  out  1  fetch read data valid
- m0_rdata  out  DATA_W  fetch read data
- m1_req  in  1  ex request
- m1_we  in  1  1 = write, 0 = read
- m1_addr  in  ADDR_W  ex address
- m1_wdata  in  DATA_W  ex write data
- m1_gnt  out  1  ex request accepted this cycle
- m1_rvalid  out  1  ex read data valid
- m1_rdata  out  DATA_W  ex read data
- s_req  out  1  memory access strobe
- s_we  out  1  memory write enable
- s_addr  out  ADDR_W  memory address
- s_wdata  out  DATA_W  memory write data
- s_rdata  in  DATA_W  memory read data, valid the cycle after an accepted read
- hold_flag_o  out  `HOLD_FLAG_BUS  HOLD_NONE / HOLD_PC / HOLD_ID

## Operation
- State machine: IDLE, RD0 (m0 read outstanding), RD1 (m1 read outstanding). Writes never leave IDLE.
- Acceptance is possible in every state. A request is accepted when its gnt is high; s_req/s_we/s_addr/s_wdata are driven combinationally from the winner.
- Arbitration among simultaneous requests: m1 wins unless starve_cnt == STARVE_MAX, in which case m0 wins.
- starve_cnt (4 bits): increments when m0_req && !m0_gnt. Saturates at STARVE_MAX. Clears on m0_gnt.
- Next state:
  - accepted m0 read -> RD0
  - accepted m1 read -> RD1
  - accepted m1 write, or no acceptance -> IDLE
- Response routing:
  - In RD0: m0_rvalid = 1 and m0_rdata = s_rdata.
  - In RD1: m1_rvalid = 1 and m1_rdata = s_rdata.
  - Otherwise rvalid = 0 and rdata = 0.
- hold_flag_o priority:
  - HOLD_ID if m1_req && !m1_gnt (stalls the pipeline through ex).
  - Otherwise HOLD_PC if m0_req && !m0_gnt.
  - Otherwise HOLD_NONE.
- Read data to ex returns one cycle after the grant, so ex holds its load until m1_rvalid. The arbiter does not reorder.

## Timing
- Reset values: state IDLE, starve_cnt 0, all gnt/rvalid 0, rdata 0, s_req 0, s_we 0, s_addr 0, s_wdata 0, hold_flag_o HOLD_NONE.
- Grant latency: 0 cycles (combinational, same cycle as req).
- Read latency: 1 cycle from grant to rvalid. Write completes in the grant cycle.
- Back-to-back: a new grant is allowed in the same cycle as an rvalid, giving 1 transaction/cycle sustained.
- Reset asserted mid-read: the outstanding read is discarded and no rvalid is produced after reset release.
- Request dropped before grant: no effect. starve_cnt still counts only cycles where m0_req is high.
- STARVE_MAX boundary: with both masters requesting continuously, m0 is granted on cycle STARVE_MAX+1 after its first denial. starve_cnt then returns to 0.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined: starvation counter and forced m0 win as described.
- Undefined: starve_cnt is not built and m1 always wins. STARVE_MAX is ignored.

## Structure
- Shared defines.v holds HOLD_FLAG_BUS, HOLD_NONE/HOLD_PC/HOLD_ID, WRITE_ENABLE/DISABLE, ZERO_WORD, and the 2-bit arbiter state encodings ARB_IDLE/ARB_RD0/ARB_RD1.
- Single module. No sub-module.

## Test plan
- m0 read of addr 0x10 alone, memory holds 0xDEADBEEF -> m0_gnt same cycle; next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF; hold HOLD_NONE.
- m0 and m1 read in the same cycle -> m1_gnt=1, m0_gnt=0, hold_flag_o=HOLD_PC; next cycle m1_rvalid=1 and m0 is granted if m1 is idle.
- m1 write 0x12345678 to 0x20, then m0 read 0x20 next cycle -> s_we=1 in cycle 1; m0_rdata=0x12345678 in cycle 3.
- Both masters requesting continuously with STARVE_MAX=4, guard enabled -> m1 granted for 4 cycles, m0 granted on the 5th, then m1 again. Guard disabled -> m0 is never granted.
- rst pulsed in the cycle after an m1 read grant -> m1_rvalid stays 0; all outputs are at reset values during rst.
- m1 request while an m0 read is outstanding (RD0) -> m1 is granted the same cycle m0_rvalid=1, and the two responses do not cross.
